// File: rtl/tpu_scratchpad_ram.sv
// Dual-port lane-masked TPU scratchpad with configurable read latency,
// read-during-write mode, write-collision flag and a memory clear engine.
module tpu_scratchpad_ram #(
  parameter int AWIDTH         = 10,
  parameter int DWIDTH         = 16,
  parameter int LANES          = 16,
  parameter int RD_LATENCY     = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    en0,
  input  logic [AWIDTH-1:0]       addr0,
  input  logic [LANES*DWIDTH-1:0] d0,
  input  logic [LANES-1:0]        we0,
  output logic [LANES*DWIDTH-1:0] q0,
  output logic                    qvalid0,
  input  logic                    en1,
  input  logic [AWIDTH-1:0]       addr1,
  input  logic [LANES*DWIDTH-1:0] d1,
  input  logic [LANES-1:0]        we1,
  output logic [LANES*DWIDTH-1:0] q1,
  output logic                    qvalid1,
  input  logic                    clr_start,
  output logic                    busy,
  output logic                    clr_done,
  output logic                    collision
);

  localparam int W     = LANES * DWIDTH;
  localparam int DEPTH = 1 << AWIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [AWIDTH-1:0] r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_coll;
  logic [W-1:0]      r_mem [DEPTH];
  logic [W-1:0]      r_q0;
  logic [W-1:0]      r_q1;
  logic              r_qv0;
  logic              r_qv1;

  logic              w_acc0;
  logic              w_acc1;
  logic [W-1:0]      w_rd0;
  logic [W-1:0]      w_rd1;

  assign w_acc0 = en0 & ~r_busy;
  assign w_acc1 = en1 & ~r_busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      r_busy  <= (CLEAR_ON_RESET != 0);
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (clr_start) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {AWIDTH{1'b1}}) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Own-port written lanes bypass the array only in write-first mode
  always_comb begin
    w_rd0 = r_mem[addr0];
    w_rd1 = r_mem[addr1];
    if (WRITE_FIRST != 0) begin
      for (int i = 0; i < LANES; i++) begin
        if (we0[i]) w_rd0[i*DWIDTH +: DWIDTH] = d0[i*DWIDTH +: DWIDTH];
        if (we1[i]) w_rd1[i*DWIDTH +: DWIDTH] = d1[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Port 1 is written last so it wins a same-lane collision
  always_ff @(posedge clk) begin
    if (r_busy) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (en0 && we0[i])
          r_mem[addr0][i*DWIDTH +: DWIDTH] <= d0[i*DWIDTH +: DWIDTH];
      for (int i = 0; i < LANES; i++)
        if (en1 && we1[i])
          r_mem[addr1][i*DWIDTH +: DWIDTH] <= d1[i*DWIDTH +: DWIDTH];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_coll <= 1'b0;
    else r_coll <= w_acc0 & w_acc1 & (addr0 == addr1) & (|(we0 & we1));
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic         r_v0;
    logic         r_v1;
    logic [W-1:0] r_d0;
    logic [W-1:0] r_d1;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_v0  <= 1'b0;
        r_v1  <= 1'b0;
        r_d0  <= '0;
        r_d1  <= '0;
        r_qv0 <= 1'b0;
        r_qv1 <= 1'b0;
        r_q0  <= '0;
        r_q1  <= '0;
      end else begin
        r_v0  <= w_acc0;
        r_v1  <= w_acc1;
        if (w_acc0) r_d0 <= w_rd0;
        if (w_acc1) r_d1 <= w_rd1;
        r_qv0 <= r_v0;
        r_qv1 <= r_v1;
        if (r_v0) r_q0 <= r_d0;
        if (r_v1) r_q1 <= r_d1;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_qv0 <= 1'b0;
        r_qv1 <= 1'b0;
        r_q0  <= '0;
        r_q1  <= '0;
      end else begin
        r_qv0 <= w_acc0;
        r_qv1 <= w_acc1;
        if (w_acc0) r_q0 <= w_rd0;
        if (w_acc1) r_q1 <= w_rd1;
      end
    end
  end

  assign q0        = r_q0;
  assign q1        = r_q1;
  assign qvalid0   = r_qv0;
  assign qvalid1   = r_qv1;
  assign busy      = r_busy;
  assign clr_done  = r_done;
  assign collision = r_coll;

endmodule
